log2_sum_acc: RTL and testbench
===============================

// Module: log2_sum_acc
// PURPOSE
// Consumes the stage-1 pow2 outputs of RU (2^((x_i-max)*log2e), Q4.12) for one softmax vector.
// Accumulates them exactly and produces log2(sum) in Q4.12 via leading-one + linear-mantissa approx.
// The result is the log2_sum operand fed back to RU in_0 for stage 2 (log2_sum - y_i).
// PARAMETERS
// DATA_W  16  input/output width, Q4.12 signed
// FRAC_W  12  fractional bits of DATA_W
// N_MAX   64  max vector length; ACC_W = DATA_W-1+$clog2(N_MAX) (=21), unsigned Q9.12
// PORTS
// clk        in   1      clock; all state updates on rising edge
// rst        in   1      synchronous, active-high reset
// en         in   1      global enable; 0 = freeze all registers, outputs hold
// start      in   1      pulse: clear accumulator, load len, enter ACC
// len        in   7      vector length 0..N_MAX, sampled with start
// in_valid   in   1      RU out_1 beat valid (driven from RU valid_out)
// in_data    in   16     RU out_1, Q4.12
// in_ready   out  1      high while in ACC (informational, no backpressure)
// out_valid  out  1      one-cycle pulse: log2_sum valid
// log2_sum   out  16     Q4.12 log2 of accumulated sum; held until next result
// busy       out  1      state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, acc=0, cnt=0, out_valid=0, log2_sum=16'h0000, busy=0, in_ready=0.
// - en=0: no register changes (incl. out_valid, which stays at its current value).
// - FSM (all transitions require en=1):
//   IDLE -start-> ACC (len>0) or CALC (len==0, acc=0)
//   ACC: each in_valid beat: acc += clamp(in_data), cnt++; the beat with cnt==len-1 -> CALC
//   CALC: register log2 result, out_valid<=1 -> DONE
//   DONE: out_valid<=0 -> IDLE
// - Latency: last beat accepted at edge k; out_valid high for the cycle after edge k+1.
// - in_data clamp: bit15=1 (negative) adds 0; else zero-extended to ACC_W. No overflow possible.
// - in_valid outside ACC: ignored, no error flag.
// - start in any state (incl. ACC/CALC/DONE): restart; acc=0, cnt=0, out_valid<=0.
//   start and in_valid in the same cycle: start wins, that beat is dropped.
// - log2: p = index of leading one of acc; int = p-FRAC_W (signed); frac = the 12 bits
//   directly below the leading one, left-aligned (zero-padded when p<12), truncated.
//   result = {int[3:0], frac}; log2(1+f) ~= f.
// - Saturation: acc==0 or int<-8 -> 16'h8000; int>7 -> 16'h7FFF.
// - rst mid-operation: immediate return to the reset state; partial sum discarded, no out_valid.
// STRUCTURE
// - Shared package softmax_pkg: DATA_W, FRAC_W, LOG2_NEG_SAT=16'h8000, LOG2_POS_SAT=16'h7FFF,
//   FSM state encoding (IDLE/ACC/CALC/DONE).
// - Sub-module log2_approx (combinational): ACC_W-bit unsigned in -> Q4.12 out,
//   leading-one detect, normalize shift and saturation. Top holds FSM, counter, accumulator.
// TESTING
// 1. start,len=4; four beats 16'h1000 -> out_valid 2 edges after last beat, log2_sum=16'h2000.
// 2. len=3; three beats 16'h1000 (sum 3.0) -> log2_sum=16'h1800 (approx 1.5).
// 3. len=1; beat 16'h0800 (0.5) -> 16'hF000; len=2, beats 0x0000,0x8000 -> 16'h8000 (zero sum).
// 4. len=4, two beats 16'h1000, start again with len=2, beats 16'h1000 x2 -> 16'h1000;
//    start+in_valid in the same cycle -> that beat not counted.
// 5. len=4, en=0 for 5 cycles between beats with in_valid held high -> no change;
//    result 16'h2000 after resume; out_valid pulse stretched while en=0 in DONE.
// 6. rst asserted after 2 of 4 beats -> all outputs at reset values, no out_valid;
//    next full run is correct. Also check len=0 -> 16'h8000 with out_valid.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg: constants and types shared by the softmax datapath blocks.
//   DATA_W / FRAC_W : Q4.12 signed operand format exchanged with RU
//   N_MAX / LEN_W   : maximum vector length and width of the length field
//   ACC_W           : exact-sum accumulator width (unsigned Q9.12)
//   LOG2_*_SAT      : saturation codes of the log2 result
//   state_t         : sequencing states of the log2-sum accumulator
package softmax_pkg;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 12;
  localparam int INT_W   = DATA_W - FRAC_W;
  localparam int N_MAX   = 64;
  localparam int LEN_W   = 7;
  localparam int ACC_W   = DATA_W - 1 + $clog2(N_MAX);
  localparam int INT_MIN = -(2 ** (INT_W - 1));
  localparam int INT_MAX = (2 ** (INT_W - 1)) - 1;

  localparam logic [DATA_W-1:0] LOG2_NEG_SAT = 16'h8000;
  localparam logic [DATA_W-1:0] LOG2_POS_SAT = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Negative pow2 outputs cannot occur legitimately; they contribute nothing.
  function automatic logic [ACC_W-1:0] clamp_beat(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1]) begin
      clamp_beat = {ACC_W{1'b0}};
    end else begin
      clamp_beat = {{(ACC_W - DATA_W){1'b0}}, d};
    end
  endfunction

endpackage

// File: rtl/log2_approx.sv
// log2_approx: combinational log2 of an unsigned Q9.12 sum, result in Q4.12.
//   acc_in   : ACC_W-bit unsigned sum
//   log2_out : {integer part, 12 mantissa bits below the leading one}
// The mantissa is used directly as log2(1+f) ~= f. Zero input and integer
// parts below -8 give LOG2_NEG_SAT; integer parts above 7 give LOG2_POS_SAT.
module log2_approx
  import softmax_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_in,
  output logic [DATA_W-1:0] log2_out
);

  localparam int P_W = $clog2(ACC_W);
  localparam logic signed [P_W:0] INT_MIN_S = (P_W + 1)'(INT_MIN);
  localparam logic signed [P_W:0] INT_MAX_S = (P_W + 1)'(INT_MAX);

  logic [P_W-1:0]    lead_s;
  logic              found_s;
  logic [ACC_W-1:0]  norm_s;
  logic [FRAC_W-1:0] frac_s;
  logic signed [P_W:0] int_s;

  // Leading-one position, normalisation shift and saturation of the result.
  always_comb begin
    lead_s = {P_W{1'b0}};
    for (int i = 0; i < ACC_W; i++) begin
      lead_s = acc_in[i] ? P_W'(i) : lead_s;
    end
    found_s = |acc_in;
    // Move the leading one to the MSB; the bits below it are the mantissa,
    // zero-padded automatically when fewer than FRAC_W bits exist below it.
    norm_s = acc_in << (P_W'(ACC_W - 1) - lead_s);
    frac_s = norm_s[ACC_W-2 -: FRAC_W];
    int_s  = $signed({1'b0, lead_s}) - $signed((P_W + 1)'(FRAC_W));
    if (!found_s) begin
      log2_out = LOG2_NEG_SAT;
    end else if (int_s < INT_MIN_S) begin
      log2_out = LOG2_NEG_SAT;
    end else if (int_s > INT_MAX_S) begin
      log2_out = LOG2_POS_SAT;
    end else begin
      log2_out = {int_s[INT_W-1:0], frac_s};
    end
  end

endmodule

// File: rtl/log2_sum_acc.sv
// log2_sum_acc: accumulates the stage-1 pow2 outputs of one softmax vector
// exactly and returns log2(sum) in Q4.12 for the stage-2 subtraction.
//   clk, rst  : clock, synchronous active-high reset
//   en        : global enable, 0 freezes every register
//   start/len : begin a vector of len beats (len==0 yields the zero-sum code)
//   in_valid/in_data : pow2 beats from RU, Q4.12
//   in_ready  : high while accumulating (informational only)
//   out_valid : one-cycle pulse with log2_sum; log2_sum holds until next result
//   busy      : sequencer not idle
module log2_sum_acc
  import softmax_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] log2_sum,
  output logic              busy
);

  state_t            state_r, state_nxt_s;
  logic [ACC_W-1:0]  acc_r, acc_nxt_s;
  logic [LEN_W-1:0]  cnt_r, cnt_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic              out_valid_r, out_valid_nxt_s;
  logic [DATA_W-1:0] log2_sum_r, log2_sum_nxt_s;
  logic              busy_r, in_ready_r;
  logic [DATA_W-1:0] approx_s;

  log2_approx u_log2_approx (
    .acc_in   (acc_r),
    .log2_out (approx_s)
  );

  // Next-state and datapath update; start overrides everything, including a beat.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    len_nxt_s       = len_r;
    out_valid_nxt_s = out_valid_r;
    log2_sum_nxt_s  = log2_sum_r;
    if (start) begin
      len_nxt_s       = len;
      acc_nxt_s       = {ACC_W{1'b0}};
      cnt_nxt_s       = {LEN_W{1'b0}};
      out_valid_nxt_s = 1'b0;
      state_nxt_s     = (len == {LEN_W{1'b0}}) ? ST_CALC : ST_ACC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ACC: begin
          if (in_valid) begin
            acc_nxt_s = acc_r + clamp_beat(in_data);
            cnt_nxt_s = cnt_r + 7'd1;
            if (cnt_r == (len_r - 7'd1)) begin
              state_nxt_s = ST_CALC;
            end else begin
              state_nxt_s = ST_ACC;
            end
          end else begin
            state_nxt_s = ST_ACC;
          end
        end
        ST_CALC: begin
          log2_sum_nxt_s  = approx_s;
          out_valid_nxt_s = 1'b1;
          state_nxt_s     = ST_DONE;
        end
        ST_DONE: begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end
        default: begin
          out_valid_nxt_s = 1'b0;
          state_nxt_s     = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs; en=0 holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      out_valid_r <= 1'b0;
      log2_sum_r  <= 16'h0000;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
    end else if (en) begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      len_r       <= len_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      log2_sum_r  <= log2_sum_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      in_ready_r  <= (state_nxt_s == ST_ACC);
    end else begin
      state_r     <= state_r;
      acc_r       <= acc_r;
      cnt_r       <= cnt_r;
      len_r       <= len_r;
      out_valid_r <= out_valid_r;
      log2_sum_r  <= log2_sum_r;
      busy_r      <= busy_r;
      in_ready_r  <= in_ready_r;
    end
  end

  assign out_valid = out_valid_r;
  assign log2_sum  = log2_sum_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_log2_sum_acc.sv
// tb_log2_sum_acc: directed scenarios plus randomized vectors for log2_sum_acc,
// checked against an arithmetic model of sum -> log2 with truncated mantissa.
module tb_log2_sum_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [6:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] log2_sum;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  log2_sum_acc dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .log2_sum  (log2_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start(input int l);
    start = 1'b1;
    len   = 7'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the edge that accepted the last beat (or the start of len=0).
  task automatic expect_result(input string tag, input logic [15:0] exp);
    check_eq({tag, "_ov_early"}, 32'(out_valid), 32'd0);
    tick();
    check_eq({tag, "_ov"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_val"}, 32'(log2_sum), 32'(exp));
    tick();
    check_eq({tag, "_ov_end"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_eq({tag, "_hold"}, 32'(log2_sum), 32'(exp));
  endtask

  // log2 of a Q.12 sum: integer part from floor(log2), mantissa from the
  // truncated fraction (sum - 2^p)/2^p, both with plain integer arithmetic.
  function automatic logic [15:0] ref_log2(input longint sum);
    int          p;
    int          ip;
    longint      frac;
    logic [3:0]  ip4;
    logic [11:0] f12;
    if (sum == 0) return 16'h8000;
    p = 0;
    while ((sum >> (p + 1)) != 0) p++;
    ip = p - 12;
    if (ip < -8) return 16'h8000;
    if (ip > 7) return 16'h7FFF;
    frac = ((sum - (longint'(1) << p)) * 4096) / (longint'(1) << p);
    ip4  = ip[3:0];
    f12  = frac[11:0];
    return {ip4, f12};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          l;
    int          mode;
    int          vmax;
    longint      sum;
    logic [15:0] d;

    rst = 1'b1; en = 1'b1; start = 1'b0; len = 7'd0; in_valid = 1'b0; in_data = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_ov", 32'(out_valid), 32'd0);
    check_eq("rst_val", 32'(log2_sum), 32'h0000);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd0);

    // 1: sum 4.0
    send_start(4);
    check_eq("t1_rdy", 32'(in_ready), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    repeat (4) send_beat(16'h1000);
    expect_result("t1", 16'h2000);

    // 2: sum 3.0
    send_start(3);
    repeat (3) send_beat(16'h1000);
    expect_result("t2", 16'h1800);

    // 3: below one, and a zero sum with a negative beat
    send_start(1);
    send_beat(16'h0800);
    expect_result("t3a", 16'hF000);
    send_start(2);
    send_beat(16'h0000);
    send_beat(16'h8000);
    expect_result("t3b", 16'h8000);

    // 4: restart mid-vector; start with a simultaneous beat drops the beat
    send_start(4);
    send_beat(16'h1000);
    send_beat(16'h1000);
    in_valid = 1'b1; in_data = 16'h1000;
    send_start(2);
    in_valid = 1'b0;
    send_beat(16'h1000);
    check_eq("t4_ov_mid", 32'(out_valid), 32'd0);
    send_beat(16'h1000);
    expect_result("t4", 16'h1000);

    // 5: freeze between beats, then freeze the output pulse
    send_start(4);
    send_beat(16'h1000);
    send_beat(16'h1000);
    en = 1'b0; in_valid = 1'b1; in_data = 16'h1000;
    repeat (5) tick();
    en = 1'b1; in_valid = 1'b0;
    check_eq("t5_busy_frz", 32'(busy), 32'd1);
    send_beat(16'h1000);
    send_beat(16'h1000);
    tick();
    check_eq("t5_ov", 32'(out_valid), 32'd1);
    check_eq("t5_val", 32'(log2_sum), 32'h2000);
    en = 1'b0;
    repeat (3) tick();
    check_eq("t5_ov_frz", 32'(out_valid), 32'd1);
    en = 1'b1;
    tick();
    check_eq("t5_ov_end", 32'(out_valid), 32'd0);

    // 6: reset mid-vector, then a clean run and a zero-length vector
    send_start(4);
    send_beat(16'h1000);
    send_beat(16'h1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_ov", 32'(out_valid), 32'd0);
    check_eq("t6_val", 32'(log2_sum), 32'h0000);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_rdy", 32'(in_ready), 32'd0);
    repeat (3) tick();
    check_eq("t6_ov_late", 32'(out_valid), 32'd0);
    send_start(4);
    repeat (4) send_beat(16'h1000);
    expect_result("t6", 16'h2000);
    send_start(0);
    expect_result("t6_len0", 16'h8000);

    // Randomized vectors: value range picks small, medium or saturating sums.
    for (int v = 0; v < 40; v++) begin
      l    = (v % 10 == 9) ? 0 : int'($urandom_range(1, 64));
      mode = int'($urandom_range(0, 2));
      vmax = (mode == 0) ? 15 : ((mode == 1) ? 1023 : 32767);
      if ($urandom_range(0, 1) == 1) begin
        send_beat(16'h1000);
      end
      send_start(l);
      sum = 0;
      for (int b = 0; b < l; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 7) == 0) begin
          en = 1'b0; in_valid = 1'b1; in_data = 16'($urandom);
          repeat (2) tick();
          en = 1'b1; in_valid = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) begin
          d = 16'h8000 | 16'($urandom_range(0, 32767));
        end else begin
          d = 16'($urandom_range(0, vmax));
        end
        if (d[15] == 1'b0) sum += longint'(d);
        send_beat(d);
      end
      expect_result("rand", ref_log2(sum));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
